// File: rtl/brch_pred_sched_ctrl.sv
// Scheduler for the correlational branch predictor: in-flight prediction queue,
// registered LHT/LPT update strobes, mispredict flush and table-clear walk.
module brch_pred_sched_ctrl #(
  parameter int IDX_W   = 5,
  parameter int Q_DEPTH = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             brch_instr_detectd_IF,
  input  logic             if_stall,
  input  logic [IDX_W-1:0] branch_addr_IF,
  input  logic             predict_br_taken,
  input  logic             brch_instr_detectd_ID,
  input  logic             brch_hazard_stall,
  input  logic             actual_brch_result,
  input  logic             soft_clear,
  output logic             upd_en,
  output logic [IDX_W-1:0] upd_addr,
  output logic             upd_result,
  output logic             clr_en,
  output logic [IDX_W-1:0] clr_addr,
  output logic             pred_busy,
  output logic             mispredict_flush,
  output logic             q_full,
  output logic             q_empty,
  output logic [1:0]       err_sticky,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(Q_DEPTH);
  localparam logic [IDX_W-1:0] CLR_MAX  = '1;

  typedef enum logic [1:0] {ST_CLEAR = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [IDX_W-1:0] qaddr_q [Q_DEPTH];
  logic             qpred_q [Q_DEPTH];

  logic             upd_en_q, upd_en_d, upd_result_q, upd_result_d;
  logic [IDX_W-1:0] upd_addr_q, upd_addr_d, clr_addr_q, clr_addr_d;
  logic             clr_en_q, clr_en_d, pred_busy_q, pred_busy_d;
  logic             flush_q, flush_d, q_full_q, q_full_d, q_empty_q, q_empty_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic run_s, push_req_s, resolve_s, pop_s, mispred_s, soft_s, drop_all_s;
  logic full_s, wr_s, ovf_s, unf_s;

  // Event decode; a resolution defers soft_clear so its update completes first.
  always_comb begin
    run_s      = (state_q == ST_RUN);
    push_req_s = run_s & brch_instr_detectd_IF & ~if_stall & ~pred_busy_q;
    resolve_s  = run_s & brch_instr_detectd_ID & ~brch_hazard_stall;
    pop_s      = resolve_s & (count_q != '0);
    unf_s      = resolve_s & (count_q == '0);
    mispred_s  = pop_s & (qpred_q[head_q] != actual_brch_result);
    soft_s     = run_s & soft_clear & ~resolve_s;
    drop_all_s = mispred_s | soft_s;
    full_s     = (count_q == FULL_CNT);
    wr_s       = push_req_s & ~drop_all_s & (~full_s | pop_s);
    ovf_s      = push_req_s & ~drop_all_s & full_s & ~pop_s;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_en_q && (clr_addr_q == CLR_MAX)) state_d = ST_RUN;
        else                                     state_d = ST_CLEAR;
      end
      ST_RUN: begin
        if (mispred_s)   state_d = ST_FLUSH;
        else if (soft_s) state_d = ST_CLEAR;
        else             state_d = ST_RUN;
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // Next values of the registered outputs and queue bookkeeping.
  always_comb begin
    clr_en_d     = (state_d == ST_CLEAR);
    clr_addr_d   = '0;
    if ((state_q == ST_CLEAR) && clr_en_q && (state_d == ST_CLEAR)) clr_addr_d = clr_addr_q + IDX_W'(1);
    else                                                            clr_addr_d = '0;
    pred_busy_d  = (state_d != ST_RUN);
    upd_en_d     = pop_s;
    upd_addr_d   = pop_s ? qaddr_q[head_q] : '0;
    upd_result_d = pop_s ? actual_brch_result : 1'b0;
    flush_d      = mispred_s;
    cnt_d        = (mispred_s && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    err_d        = err_q | {unf_s, ovf_s};
    if (drop_all_s) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop_s);
      tail_d  = tail_q + PTR_W'(wr_s);
      count_d = count_q + (PTR_W+1)'(wr_s) - (PTR_W+1)'(pop_s);
    end
    q_full_d  = (count_d == FULL_CNT);
    q_empty_d = (count_d == '0);
  end

  // Output, pointer and queue storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      upd_en_q     <= 1'b0;
      upd_addr_q   <= '0;
      upd_result_q <= 1'b0;
      clr_en_q     <= 1'b0;
      clr_addr_q   <= '0;
      pred_busy_q  <= 1'b1;
      flush_q      <= 1'b0;
      q_full_q     <= 1'b0;
      q_empty_q    <= 1'b1;
      err_q        <= 2'b00;
      cnt_q        <= '0;
      for (int i = 0; i < Q_DEPTH; i++) begin
        qaddr_q[i] <= '0;
        qpred_q[i] <= 1'b0;
      end
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      upd_en_q     <= upd_en_d;
      upd_addr_q   <= upd_addr_d;
      upd_result_q <= upd_result_d;
      clr_en_q     <= clr_en_d;
      clr_addr_q   <= clr_addr_d;
      pred_busy_q  <= pred_busy_d;
      flush_q      <= flush_d;
      q_full_q     <= q_full_d;
      q_empty_q    <= q_empty_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      if (wr_s) begin
        qaddr_q[tail_q] <= branch_addr_IF;
        qpred_q[tail_q] <= predict_br_taken;
      end
    end
  end

  assign upd_en           = upd_en_q;
  assign upd_addr         = upd_addr_q;
  assign upd_result       = upd_result_q;
  assign clr_en           = clr_en_q;
  assign clr_addr         = clr_addr_q;
  assign pred_busy        = pred_busy_q;
  assign mispredict_flush = flush_q;
  assign q_full           = q_full_q;
  assign q_empty          = q_empty_q;
  assign err_sticky       = err_q;
  assign mispredict_cnt   = cnt_q;

endmodule

// File: tb/tb_brch_pred_sched_ctrl.sv
// Table-driven bench for brch_pred_sched_ctrl with an update scoreboard and
// hand-written clear-walk / soft-clear / mid-walk reset sequences.
module tb_brch_pred_sched_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       if_v, if_stall, pred, id_v, hz, act, sc;
  logic [4:0] baddr;
  logic       upd_en, upd_result, clr_en, pred_busy, flush, q_full, q_empty;
  logic [4:0] upd_addr, clr_addr;
  logic [1:0] err;
  logic [15:0] mcnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       if_v, stall;
    logic [4:0] addr;
    logic       pred, id_v, hz, act, sc;
    logic       e_upd;
    logic [4:0] e_uaddr;
    logic       e_ures, e_flush, e_full, e_empty, e_busy;
    logic [1:0] e_err;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] sb_q[$];

  brch_pred_sched_ctrl #(.IDX_W(5), .Q_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .brch_instr_detectd_IF(if_v), .if_stall(if_stall), .branch_addr_IF(baddr),
    .predict_br_taken(pred), .brch_instr_detectd_ID(id_v), .brch_hazard_stall(hz),
    .actual_brch_result(act), .soft_clear(sc),
    .upd_en(upd_en), .upd_addr(upd_addr), .upd_result(upd_result),
    .clr_en(clr_en), .clr_addr(clr_addr), .pred_busy(pred_busy),
    .mispredict_flush(flush), .q_full(q_full), .q_empty(q_empty),
    .err_sticky(err), .mispredict_cnt(mcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_v = 1'b0; if_stall = 1'b0; baddr = 5'd0; pred = 1'b0;
    id_v = 1'b0; hz = 1'b0; act = 1'b0; sc = 1'b0;
  endtask

  task automatic add(input logic iv, input logic st, input logic [4:0] a, input logic p,
                     input logic dv, input logic h, input logic r, input logic s,
                     input logic eu, input logic [4:0] ea, input logic er, input logic ef,
                     input logic efl, input logic eem, input logic eb, input logic [1:0] ee,
                     input logic [15:0] ec);
    vec_t v;
    v.if_v = iv; v.stall = st; v.addr = a; v.pred = p; v.id_v = dv; v.hz = h; v.act = r; v.sc = s;
    v.e_upd = eu; v.e_uaddr = ea; v.e_ures = er; v.e_flush = ef; v.e_full = efl;
    v.e_empty = eem; v.e_busy = eb; v.e_err = ee; v.e_cnt = ec;
    vecs.push_back(v);
  endtask

  task automatic walk_check(input string tag);
    for (int a = 0; a < 32; a++) begin
      tick();
      chk($sformatf("%s.clr_en%0d", tag, a), 32'(clr_en), 32'd1);
      chk($sformatf("%s.clr_addr%0d", tag, a), 32'(clr_addr), 32'(a));
      chk($sformatf("%s.busy%0d", tag, a), 32'(pred_busy), 32'd1);
    end
    tick();
    chk({tag, ".run_busy"}, 32'(pred_busy), 32'd0);
    chk({tag, ".run_clr_en"}, 32'(clr_en), 32'd0);
    chk({tag, ".run_clr_addr"}, 32'(clr_addr), 32'd0);
    chk({tag, ".run_empty"}, 32'(q_empty), 32'd1);
  endtask

  initial begin
    logic [5:0] exp_u;
    // if st addr p id hz act sc | upd uaddr ures flush full empty busy err cnt
    add(1,0, 5,1, 0,0,0,0, 0, 0,0, 0,0,0,0,2'b00,16'd0);
    add(0,0, 0,0, 1,0,1,0, 1, 5,1, 0,0,1,0,2'b00,16'd0);
    add(0,0, 0,0, 0,0,0,0, 0, 0,0, 0,0,1,0,2'b00,16'd0);
    add(1,0, 3,0, 0,0,0,0, 0, 0,0, 0,0,0,0,2'b00,16'd0);
    add(1,0, 7,1, 0,0,0,0, 0, 0,0, 0,0,0,0,2'b00,16'd0);
    add(1,0, 9,1, 0,0,0,0, 0, 0,0, 0,0,0,0,2'b00,16'd0);
    add(0,0, 0,0, 1,0,1,0, 1, 3,1, 1,0,1,1,2'b00,16'd1);   // mispredict on addr 3
    add(1,0,11,1, 1,0,1,0, 0, 0,0, 0,0,1,0,2'b00,16'd1);   // FLUSH cycle ignores inputs
    add(0,0, 0,0, 0,0,0,0, 0, 0,0, 0,0,1,0,2'b00,16'd1);
    add(1,0, 1,0, 0,0,0,0, 0, 0,0, 0,0,0,0,2'b00,16'd1);
    add(1,0, 2,0, 0,0,0,0, 0, 0,0, 0,0,0,0,2'b00,16'd1);
    add(1,0, 3,0, 0,0,0,0, 0, 0,0, 0,0,0,0,2'b00,16'd1);
    add(1,0, 4,0, 0,0,0,0, 0, 0,0, 0,1,0,0,2'b00,16'd1);
    add(1,0, 6,0, 0,0,0,0, 0, 0,0, 0,1,0,0,2'b01,16'd1);   // overflow drops addr 6
    add(0,0, 0,0, 1,0,0,0, 1, 1,0, 0,0,0,0,2'b01,16'd1);
    add(0,0, 0,0, 1,0,0,0, 1, 2,0, 0,0,0,0,2'b01,16'd1);
    add(1,0, 8,0, 0,0,0,0, 0, 0,0, 0,0,0,0,2'b01,16'd1);
    add(1,0,10,0, 0,0,0,0, 0, 0,0, 0,1,0,0,2'b01,16'd1);
    add(1,0,12,0, 1,0,0,0, 1, 3,0, 0,1,0,0,2'b01,16'd1);   // push+pop at full
    add(0,0, 0,0, 1,0,0,0, 1, 4,0, 0,0,0,0,2'b01,16'd1);
    add(0,0, 0,0, 1,0,0,0, 1, 8,0, 0,0,0,0,2'b01,16'd1);
    add(0,0, 0,0, 1,0,0,0, 1,10,0, 0,0,0,0,2'b01,16'd1);
    add(0,0, 0,0, 1,0,0,0, 1,12,0, 0,0,1,0,2'b01,16'd1);
    add(0,0, 0,0, 1,0,1,0, 0, 0,0, 0,0,1,0,2'b11,16'd1);   // resolve while empty
    add(1,1,13,1, 0,0,0,0, 0, 0,0, 0,0,1,0,2'b11,16'd1);   // if_stall blocks push
    add(0,0, 0,0, 1,1,1,0, 0, 0,0, 0,0,1,0,2'b11,16'd1);   // hazard blocks resolve
    add(1,0,14,1, 0,0,0,0, 0, 0,0, 0,0,0,0,2'b11,16'd1);
    add(1,0,15,0, 1,0,0,0, 1,14,0, 1,0,1,1,2'b11,16'd2);   // mispredict drops same-cycle push
    add(0,0, 0,0, 0,0,0,0, 0, 0,0, 0,0,1,0,2'b11,16'd2);
    add(1,0,16,1, 0,0,0,0, 0, 0,0, 0,0,0,0,2'b11,16'd2);
    add(1,0,17,1, 0,0,0,0, 0, 0,0, 0,0,0,0,2'b11,16'd2);
    add(0,0, 0,0, 1,0,1,1, 1,16,1, 0,0,0,0,2'b11,16'd2);   // resolve defers soft_clear

    idle();
    #12;
    chk("rst.busy", 32'(pred_busy), 32'd1);
    chk("rst.empty", 32'(q_empty), 32'd1);
    chk("rst.clr_en", 32'(clr_en), 32'd0);
    chk("rst.upd_en", 32'(upd_en), 32'd0);
    chk("rst.full", 32'(q_full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    walk_check("walk0");

    for (int i = 0; i < vecs.size(); i++) begin
      if_v = vecs[i].if_v; if_stall = vecs[i].stall; baddr = vecs[i].addr; pred = vecs[i].pred;
      id_v = vecs[i].id_v; hz = vecs[i].hz; act = vecs[i].act; sc = vecs[i].sc;
      if (vecs[i].e_upd) sb_q.push_back({vecs[i].e_uaddr, vecs[i].e_ures});
      tick();
      chk($sformatf("v%0d.upd_en", i), 32'(upd_en), 32'(vecs[i].e_upd));
      if (upd_en === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk($sformatf("v%0d.sb_nonempty", i), 32'd0, 32'd1);
        end else begin
          exp_u = sb_q.pop_front();
          chk($sformatf("v%0d.upd_addr", i), 32'(upd_addr), 32'(exp_u[5:1]));
          chk($sformatf("v%0d.upd_result", i), 32'(upd_result), 32'(exp_u[0]));
        end
      end
      chk($sformatf("v%0d.flush", i), 32'(flush), 32'(vecs[i].e_flush));
      chk($sformatf("v%0d.full", i), 32'(q_full), 32'(vecs[i].e_full));
      chk($sformatf("v%0d.empty", i), 32'(q_empty), 32'(vecs[i].e_empty));
      chk($sformatf("v%0d.busy", i), 32'(pred_busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d.err", i), 32'(err), 32'(vecs[i].e_err));
      chk($sformatf("v%0d.cnt", i), 32'(mcnt), 32'(vecs[i].e_cnt));
    end
    chk("sb.drained", 32'(sb_q.size()), 32'd0);

    // soft_clear with addr 17 still queued: it must never update
    idle();
    sc = 1'b1;
    tick();
    sc = 1'b0;
    chk("sc.busy", 32'(pred_busy), 32'd1);
    chk("sc.empty", 32'(q_empty), 32'd1);
    chk("sc.clr_en", 32'(clr_en), 32'd1);
    chk("sc.clr_addr", 32'(clr_addr), 32'd0);
    chk("sc.upd_en", 32'(upd_en), 32'd0);
    for (int k = 1; k < 16; k++) begin
      if_v = 1'b1; baddr = 5'(k); id_v = 1'b1; act = k[0];
      tick();
      chk($sformatf("scw.clr_addr%0d", k), 32'(clr_addr), 32'(k));
      chk($sformatf("scw.upd_en%0d", k), 32'(upd_en), 32'd0);
      chk($sformatf("scw.err%0d", k), 32'(err), 32'd3);
    end
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst.clr_addr", 32'(clr_addr), 32'd0);
    chk("mrst.clr_en", 32'(clr_en), 32'd0);
    chk("mrst.busy", 32'(pred_busy), 32'd1);
    chk("mrst.err", 32'(err), 32'd0);
    chk("mrst.cnt", 32'(mcnt), 32'd0);
    chk("mrst.empty", 32'(q_empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    walk_check("walk1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
